// File: rtl/lstm_train_pkg.sv
// Shared definitions for the LSTM training sequencer.
// Contents:
//   - seq_state_t : sequencer state encoding
//   - TMO_W       : width of the wait-state timeout counter
//   - bitwidth()  : Q(QN.QM) word width, QN + QM + sign bit
//   - one_val()   : fixed-point 1.0 in Q(QN.QM)
//   - half_val()  : fixed-point 0.5 in Q(QN.QM)
package lstm_train_pkg;

    localparam int TMO_W = 12;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_NRST     = 4'd1,
        ST_GET      = 4'd2,
        ST_ISSUE    = 4'd3,
        ST_WAIT_NET = 4'd4,
        ST_SETTLE   = 4'd5,
        ST_EN_P     = 4'd6,
        ST_WAIT_P   = 4'd7,
        ST_COST     = 4'd8,
        ST_GAP      = 4'd9,
        ST_PULSE    = 4'd10,
        ST_WAIT_TRN = 4'd11,
        ST_DONE     = 4'd12,
        ST_ERROR    = 4'd13
    } seq_state_t;

    function automatic int bitwidth(input int qn, input int qm);
        return qn + qm + 32'sd1;
    endfunction

    function automatic int one_val(input int qm);
        return 32'sd1 << qm;
    endfunction

    function automatic int half_val(input int qm);
        return 32'sd1 << (qm - 32'sd1);
    endfunction

endpackage

// File: rtl/train_sequencer_cost_unit.sv
// cost_unit: purely combinational cost path for the training sequencer.
// Hard sigmoid s = clamp((y>>>2) + HALF, 0, ONE), error d = target*ONE - s,
// cost = (d*d) >> QM, prediction = (s >= HALF).
// Ports:
//   y      in  BITWIDTH  signed perceptron output
//   target in  1         expected output bit
//   cost   out BITWIDTH  unsigned squared-error cost, at most ONE
//   pred   out 1         predicted output bit
module cost_unit
    import lstm_train_pkg::*;
#(
    parameter int QN = 6,
    parameter int QM = 11
)(
    input  logic [bitwidth(QN, QM)-1:0] y,
    input  logic                        target,
    output logic [bitwidth(QN, QM)-1:0] cost,
    output logic                        pred
);

    localparam int BW   = bitwidth(QN, QM);
    localparam int SQ_W = 2 * QM + 4;

    localparam logic signed [BW:0]   HALF_W = (BW + 1)'(half_val(QM));
    localparam logic signed [BW:0]   ONE_W  = (BW + 1)'(one_val(QM));
    localparam logic [QM:0]          ONE_S  = (QM + 1)'(one_val(QM));
    localparam logic [QM:0]          HALF_S = (QM + 1)'(half_val(QM));
    localparam logic signed [QM+1:0] ONE_D  = (QM + 2)'(one_val(QM));
    localparam logic signed [QM+1:0] ZERO_D = (QM + 2)'(0);

    logic signed [BW-1:0]   y_shift_s;
    logic signed [BW:0]     s_sum_s;
    logic [QM:0]            s_s;
    logic signed [QM+1:0]   d_s;
    logic [SQ_W-1:0]        d_ext_s;
    logic [SQ_W-1:0]        sq_s;

    // Hard sigmoid; one extra bit on the sum keeps the sign visible before clamping
    always_comb begin
        y_shift_s = $signed(y) >>> 32'd2;
        s_sum_s   = $signed({y_shift_s[BW-1], y_shift_s}) + HALF_W;
        if (s_sum_s[BW]) begin
            s_s = {(QM + 1){1'b0}};
        end else if (s_sum_s > ONE_W) begin
            s_s = ONE_S;
        end else begin
            s_s = s_sum_s[QM:0];
        end
    end

    // Error, square and prediction; the square is taken on a sign-extended copy so
    // the low product bits are the exact two's-complement result
    always_comb begin
        d_s     = (target ? ONE_D : ZERO_D) - $signed({1'b0, s_s});
        d_ext_s = {{(SQ_W - QM - 2){d_s[QM+1]}}, d_s};
        sq_s    = d_ext_s * d_ext_s;
        cost    = BW'(sq_s >> QM);
        pred    = (s_s >= HALF_S);
    end

endmodule

// File: rtl/train_sequencer.sv
// train_sequencer: steps samples through the LSTM network and perceptron, computes
// the squared-error cost, hands it to the perturbation trainer and waits for updates.
// Ports (all outputs registered, cleared by active-low async reset):
//   clock, reset                      clock and async active-low reset
//   start, trainEnable                begin a sequence / select training mode
//   sampleValid/sampleReady/sampleX/sampleTarget   sample source handshake
//   netReset, inputVec, newSample     network control and data
//   dataReady, enPerceptron, dataReadyP, networkOutput   layer/perceptron interface
//   costFunc, newCostFunc, trainingReady                 trainer interface
//   predBit, predValid, errCount      prediction and mismatch count
//   busy, done, timeoutErr            status
module train_sequencer
    import lstm_train_pkg::*;
#(
    parameter int HIDDEN_SZ = 8,
    parameter int INPUT_SZ  = 2,
    parameter int QN        = 6,
    parameter int QM        = 11,
    parameter int SEQ_LEN   = 8,
    parameter int TIMEOUT   = 4095
)(
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  trainEnable,
    input  logic                                  sampleValid,
    output logic                                  sampleReady,
    input  logic [INPUT_SZ*bitwidth(QN, QM)-1:0]  sampleX,
    input  logic                                  sampleTarget,
    output logic                                  netReset,
    output logic [INPUT_SZ*bitwidth(QN, QM)-1:0]  inputVec,
    output logic                                  newSample,
    input  logic                                  dataReady,
    output logic                                  enPerceptron,
    input  logic                                  dataReadyP,
    input  logic [bitwidth(QN, QM)-1:0]           networkOutput,
    output logic [bitwidth(QN, QM)-1:0]           costFunc,
    output logic                                  newCostFunc,
    input  logic                                  trainingReady,
    output logic                                  predBit,
    output logic                                  predValid,
    output logic [15:0]                           errCount,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  timeoutErr
);

    localparam int BW     = bitwidth(QN, QM);
    localparam int STEP_W = $clog2(SEQ_LEN + 32'sd1);

    // The hidden size only documents the attached network; it shapes no logic here
    if (HIDDEN_SZ < 32'sd1) begin : g_hidden_unused
    end

    seq_state_t        state_r;
    seq_state_t        next_state_s;
    logic [TMO_W-1:0]  tmo_r;
    logic              tmo_hit_s;
    logic              start_ok_s;
    logic              last_step_s;
    logic [STEP_W-1:0] step_r;
    logic              pass_r;
    logic              train_en_r;
    logic              target_r;
    logic              dr_d_r;
    logic              drp_d_r;
    logic              trn_d_r;
    logic              dr_edge_r;
    logic              drp_edge_r;
    logic              trn_edge_r;
    logic [BW-1:0]     cost_s;
    logic              pred_s;

    cost_unit #(
        .QN (QN),
        .QM (QM)
    ) u_cost (
        .y      (networkOutput),
        .target (target_r),
        .cost   (cost_s),
        .pred   (pred_s)
    );

    always_comb begin
        tmo_hit_s   = (32'(tmo_r) >= 32'(TIMEOUT));
        start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                (state_r == ST_ERROR));
        last_step_s = ((32'(step_r) + 32'd1) >= 32'(SEQ_LEN));
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) next_state_s = ST_NRST;
                else       next_state_s = state_r;
            end
            // tmo_r restarts on entry, so it doubles as the two-cycle reset timer
            ST_NRST: begin
                if (tmo_r == {{(TMO_W - 1){1'b0}}, 1'b1}) next_state_s = ST_GET;
                else                                       next_state_s = ST_NRST;
            end
            ST_GET: begin
                if (sampleValid)    next_state_s = ST_ISSUE;
                else if (tmo_hit_s) next_state_s = ST_ERROR;
                else                next_state_s = ST_GET;
            end
            ST_ISSUE:  next_state_s = ST_WAIT_NET;
            ST_WAIT_NET: begin
                if (dr_edge_r)      next_state_s = ST_SETTLE;
                else if (tmo_hit_s) next_state_s = ST_ERROR;
                else                next_state_s = ST_WAIT_NET;
            end
            ST_SETTLE: next_state_s = ST_EN_P;
            ST_EN_P:   next_state_s = ST_WAIT_P;
            ST_WAIT_P: begin
                if (drp_edge_r)     next_state_s = ST_COST;
                else if (tmo_hit_s) next_state_s = ST_ERROR;
                else                next_state_s = ST_WAIT_P;
            end
            ST_COST:   next_state_s = ST_GAP;
            ST_GAP:    next_state_s = ST_PULSE;
            ST_PULSE: begin
                if (!pass_r && train_en_r) next_state_s = ST_WAIT_NET;
                else                       next_state_s = ST_WAIT_TRN;
            end
            ST_WAIT_TRN: begin
                if (!train_en_r || trn_edge_r) begin
                    if (last_step_s) next_state_s = ST_DONE;
                    else             next_state_s = ST_GET;
                end else if (tmo_hit_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_WAIT_TRN;
                end
            end
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= next_state_s;
    end

    // Rising-edge detectors; a level already high never produces an edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dr_d_r     <= 1'b0;
            drp_d_r    <= 1'b0;
            trn_d_r    <= 1'b0;
            dr_edge_r  <= 1'b0;
            drp_edge_r <= 1'b0;
            trn_edge_r <= 1'b0;
        end else begin
            dr_d_r     <= dataReady;
            drp_d_r    <= dataReadyP;
            trn_d_r    <= trainingReady;
            dr_edge_r  <= dataReady & ~dr_d_r;
            drp_edge_r <= dataReadyP & ~drp_d_r;
            trn_edge_r <= trainingReady & ~trn_d_r;
        end
    end

    // Timeout counter (cleared on every state change), step, pass and captured sample
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_r      <= {TMO_W{1'b0}};
            step_r     <= {STEP_W{1'b0}};
            pass_r     <= 1'b0;
            train_en_r <= 1'b0;
            target_r   <= 1'b0;
            inputVec   <= {(INPUT_SZ * BW){1'b0}};
        end else begin
            if (state_r != next_state_s)  tmo_r <= {TMO_W{1'b0}};
            else if (tmo_r != {TMO_W{1'b1}}) tmo_r <= tmo_r + {{(TMO_W - 1){1'b0}}, 1'b1};
            else                          tmo_r <= tmo_r;

            if (start_ok_s) step_r <= {STEP_W{1'b0}};
            else if ((state_r == ST_WAIT_TRN) &&
                     ((next_state_s == ST_GET) || (next_state_s == ST_DONE)))
                step_r <= step_r + {{(STEP_W - 1){1'b0}}, 1'b1};
            else step_r <= step_r;

            if (state_r == ST_GET)        pass_r <= 1'b0;
            else if (state_r == ST_PULSE) pass_r <= 1'b1;
            else                          pass_r <= pass_r;

            if (start_ok_s) train_en_r <= trainEnable;
            else            train_en_r <= train_en_r;

            if ((state_r == ST_GET) && sampleValid) begin
                inputVec <= sampleX;
                target_r <= sampleTarget;
            end else begin
                inputVec <= inputVec;
                target_r <= target_r;
            end
        end
    end

    // Outputs registered from the state being entered, so each lines up with its state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            netReset     <= 1'b0;
            sampleReady  <= 1'b0;
            newSample    <= 1'b0;
            enPerceptron <= 1'b0;
            newCostFunc  <= 1'b0;
            predValid    <= 1'b0;
            predBit      <= 1'b0;
            costFunc     <= {BW{1'b0}};
            errCount     <= 16'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeoutErr   <= 1'b0;
        end else begin
            netReset     <= (next_state_s == ST_NRST);
            sampleReady  <= (next_state_s == ST_GET);
            newSample    <= (next_state_s == ST_ISSUE);
            enPerceptron <= (next_state_s == ST_EN_P) || (next_state_s == ST_WAIT_P);
            newCostFunc  <= (next_state_s == ST_PULSE);
            predValid    <= (next_state_s == ST_COST) && !pass_r;
            busy         <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE) &&
                            (next_state_s != ST_ERROR);
            done         <= (next_state_s == ST_DONE);
            // ERROR is left only through start, so the flag stays set until then
            timeoutErr   <= (next_state_s == ST_ERROR);

            if (next_state_s == ST_COST) costFunc <= cost_s;
            else                         costFunc <= costFunc;

            if ((next_state_s == ST_COST) && !pass_r) predBit <= pred_s;
            else                                      predBit <= predBit;

            if (start_ok_s)
                errCount <= 16'd0;
            else if ((next_state_s == ST_COST) && !pass_r && (pred_s != target_r) &&
                     (errCount != 16'hFFFF))
                errCount <= errCount + 16'd1;
            else
                errCount <= errCount;
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// Self-checking bench for train_sequencer: directed steps with random samples,
// network/perceptron/trainer responses driven by the bench, and a cost model
// computed from the Q-format arithmetic rules.
module tb_train_sequencer;

    localparam int BW      = 18;
    localparam int XW      = 36;
    localparam int ONE     = 2048;
    localparam int HALF    = 1024;
    localparam int SEQ_LEN = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          trainEnable = 1'b0;
    logic          sampleValid = 1'b0;
    logic          sampleReady;
    logic [XW-1:0] sampleX = '0;
    logic          sampleTarget = 1'b0;
    logic          netReset;
    logic [XW-1:0] inputVec;
    logic          newSample;
    logic          dataReady = 1'b0;
    logic          enPerceptron;
    logic          dataReadyP = 1'b0;
    logic [BW-1:0] networkOutput = '0;
    logic [BW-1:0] costFunc;
    logic          newCostFunc;
    logic          trainingReady = 1'b0;
    logic          predBit;
    logic          predValid;
    logic [15:0]   errCount;
    logic          busy;
    logic          done;
    logic          timeoutErr;

    int total = 0;
    int bad = 0;
    int model_err = 0;
    int n_new_sample = 0;
    int n_cost_pulse = 0;
    int n_pred_valid = 0;

    train_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .trainEnable(trainEnable),
        .sampleValid(sampleValid), .sampleReady(sampleReady), .sampleX(sampleX),
        .sampleTarget(sampleTarget), .netReset(netReset), .inputVec(inputVec),
        .newSample(newSample), .dataReady(dataReady), .enPerceptron(enPerceptron),
        .dataReadyP(dataReadyP), .networkOutput(networkOutput), .costFunc(costFunc),
        .newCostFunc(newCostFunc), .trainingReady(trainingReady), .predBit(predBit),
        .predValid(predValid), .errCount(errCount), .busy(busy), .done(done),
        .timeoutErr(timeoutErr)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (newSample)   n_new_sample <= n_new_sample + 1;
        if (newCostFunc) n_cost_pulse <= n_cost_pulse + 1;
        if (predValid)   n_pred_valid <= n_pred_valid + 1;
    end

    // Reference: hard sigmoid, squared error and prediction from the Q-format rules
    function automatic int model_s(input int y);
        int s;
        s = (y >>> 2) + HALF;
        if (s < 0) s = 0;
        else if (s > ONE) s = ONE;
        return s;
    endfunction

    function automatic int model_cost(input int y, input int t);
        int d;
        d = t * ONE - model_s(y);
        return (d * d) / ONE;
    endfunction

    function automatic int model_pred(input int y);
        return (model_s(y) >= HALF) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return sampleReady;
            1:       return enPerceptron;
            default: return done;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        int n = 0;
        while (!pick(sel) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, pick(sel), 1'b1);
    endtask

    task automatic do_start(input logic tr);
        start = 1'b1;
        trainEnable = tr;
        @(negedge clock);
        start = 1'b0;
        model_err = 0;
        check("nrst_cycle1", netReset, 1'b1);
        check("clr_timeout", timeoutErr, 1'b0);
        check("clr_done", done, 1'b0);
        check("clr_err_count", errCount, 16'd0);
        @(negedge clock);
        check("nrst_cycle2", netReset, 1'b1);
        @(negedge clock);
        check("nrst_end", netReset, 1'b0);
        check("ready_after_nrst", sampleReady, 1'b1);
    endtask

    // One nominal or perturbed pass, from the network edge to the trainer strobe
    task automatic do_pass(input int y, input logic tgt, input logic pass1, output int cost);
        repeat ($urandom_range(3, 1)) @(negedge clock);
        dataReady = 1'b1;
        wait_for(1, 20, "wait_en");
        networkOutput = BW'(y);
        repeat ($urandom_range(2, 0)) @(negedge clock);
        dataReadyP = 1'b1;
        @(negedge clock);
        check("en_hold", enPerceptron, 1'b1);
        @(negedge clock);
        cost = int'(costFunc);
        check("en_drop", enPerceptron, 1'b0);
        check("cost", costFunc, model_cost(y, int'(tgt)));
        if (!pass1) begin
            if (model_pred(y) != int'(tgt) && model_err < 65535) model_err++;
            check("pred_valid", predValid, 1'b1);
            check("pred_bit", predBit, model_pred(y));
            check("err_count", errCount, model_err);
        end else begin
            check("pred_valid_pass1", predValid, 1'b0);
        end
        @(negedge clock);
        check("ncf_early", newCostFunc, 1'b0);
        @(negedge clock);
        check("ncf_latency", newCostFunc, 1'b1);
        dataReady = 1'b0;
        dataReadyP = 1'b0;
        trainingReady = 1'b0;
    endtask

    task automatic run_step(input int y0, input int y1, input logic tgt, input logic train,
                            output int cost0);
        logic [XW-1:0] xv;
        int c1;
        xv = {4'($urandom), 32'($urandom)};
        wait_for(0, 50, "wait_ready");
        sampleValid = 1'b1;
        sampleX = xv;
        sampleTarget = tgt;
        @(negedge clock);
        sampleValid = 1'b0;
        check("new_sample", newSample, 1'b1);
        check("input_vec", inputVec, xv);
        do_pass(y0, tgt, 1'b0, cost0);
        if (train) begin
            do_pass(y1, tgt, 1'b1, c1);
            repeat ($urandom_range(4, 1)) @(negedge clock);
            trainingReady = 1'b1;
        end
    endtask

    initial begin
        int dir_y [3];
        int dir_t [3];
        int dir_c [3];
        int y0, y1, c0, n;
        int base_ns, base_cp, base_pv;
        logic tg;

        dir_y = '{0, 4096, -8192};
        dir_t = '{1, 0, 0};
        dir_c = '{512, 2048, 0};

        repeat (3) @(negedge clock);
        check("reset_outputs", |{sampleReady, netReset, inputVec, newSample, enPerceptron,
              costFunc, newCostFunc, predBit, predValid, errCount, busy, done, timeoutErr},
              1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_busy", busy, 1'b0);

        // Training sequence: directed corner samples first, then random ones
        base_ns = n_new_sample; base_cp = n_cost_pulse; base_pv = n_pred_valid;
        do_start(1'b1);
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (i < 3) begin
                y0 = dir_y[i];
                tg = dir_t[i][0];
            end else begin
                y0 = int'($urandom_range(32767, 0)) - 16384;
                tg = 1'($urandom);
            end
            y1 = int'($urandom_range(32767, 0)) - 16384;
            run_step(y0, y1, tg, 1'b1, c0);
            if (i < 3) check("directed_cost", c0, dir_c[i]);
        end
        wait_for(2, 50, "wait_done_train");
        check("busy_after_done", busy, 1'b0);
        check("count_new_sample", n_new_sample - base_ns, SEQ_LEN);
        check("count_new_cost", n_cost_pulse - base_cp, 2 * SEQ_LEN);
        check("count_pred_valid", n_pred_valid - base_pv, SEQ_LEN);

        // Inference-only sequence: no perturbed pass and no trainer wait
        base_ns = n_new_sample; base_cp = n_cost_pulse; base_pv = n_pred_valid;
        do_start(1'b0);
        for (int i = 0; i < SEQ_LEN; i++) begin
            y0 = int'($urandom_range(32767, 0)) - 16384;
            run_step(y0, 0, 1'($urandom), 1'b0, c0);
        end
        wait_for(2, 50, "wait_done_infer");
        check("count_new_sample_inf", n_new_sample - base_ns, SEQ_LEN);
        check("count_new_cost_inf", n_cost_pulse - base_cp, SEQ_LEN);
        check("count_pred_valid_inf", n_pred_valid - base_pv, SEQ_LEN);

        // dataReady already high before WAIT_NET and never rising again -> timeout
        do_start(1'b1);
        dataReady = 1'b1;
        repeat (2) @(negedge clock);
        sampleValid = 1'b1;
        @(negedge clock);
        sampleValid = 1'b0;
        check("new_sample_held", newSample, 1'b1);
        repeat (40) @(negedge clock);
        check("no_advance_on_level", enPerceptron, 1'b0);
        check("still_busy", busy, 1'b1);
        n = 40;
        while (!timeoutErr && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("timeout_window", (n >= 4090 && n <= 4105), 1'b1);
        check("timeout_flag", timeoutErr, 1'b1);
        check("timeout_en_off", enPerceptron, 1'b0);
        check("timeout_not_busy", busy, 1'b0);
        dataReady = 1'b0;
        repeat (3) @(negedge clock);
        check("timeout_sticky", timeoutErr, 1'b1);

        // Reset asserted while waiting on the perceptron
        do_start(1'b1);
        sampleValid = 1'b1;
        @(negedge clock);
        sampleValid = 1'b0;
        repeat (2) @(negedge clock);
        dataReady = 1'b1;
        wait_for(1, 20, "wait_en_rst");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_reset_outputs", |{sampleReady, netReset, inputVec, newSample,
              enPerceptron, costFunc, newCostFunc, predBit, predValid, errCount, busy,
              done, timeoutErr}, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        dataReady = 1'b0;
        @(negedge clock);
        do_start(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
